mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the pipelined RV32I core; it consumes the execute stage's results: ALU result, store data (rs2) and branch flag, handed over with a valid pulse.
- Drives the data-memory request/response interface for loads and stores, builds store byte masks, aligns and extends load data.
- Returns a registered writeback result with a one-cycle ready pulse, a stall signal for upstream stages, and forwarding data back toward execute.

Parameters:
- None. Datapath fixed at 32 bits (RV32I).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- exe_mem_valid  in  1  execute result valid this cycle (execute's ready pulse)
- alu_out_i  in  32  ALU result: effective address for load/store, writeback value otherwise
- rs2_out_i  in  32  store data
- br_en_i  in  1  branch/compare result from execute
- ld_en  in  1  instruction is a load
- st_en  in  1  instruction is a store; ld_en and st_en never both 1
- funct3  in  3  width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- dmem_address  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_read  out  1  load request, held until dmem_resp
- dmem_write  out  1  store request, held until dmem_resp
- dmem_wmask  out  4  store byte enables
- dmem_wdata  out  32  store data, lane-replicated
- dmem_rdata  in  32  load data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion from data memory
- mem_busy  out  1  stall to upstream stages; new input ignored while 1
- mem_rdy  out  1  one-cycle pulse: result fields valid
- mem_result  out  32  load data (extended) or alu_out pass-through
- mem_fwd_data  out  32  last completed result, held until the next completion
- br_en_o  out  1  registered br_en_i of the completed instruction
- mem_err  out  1  with mem_rdy: misaligned access or illegal funct3

Behaviour:
- Reset: state IDLE; every output 0. Reset during ACCESS drops dmem_read/dmem_write immediately; a late dmem_resp arriving in IDLE is ignored.
- States:
  - IDLE, DONE: accepting states; mem_busy=0.
  - ACCESS: mem_busy=1.
- Accept: in IDLE or DONE with exe_mem_valid=1, latch all inputs. Next state:
  - ACCESS if a legal, aligned load or store.
  - DONE otherwise, including non-memory ops and error cases.
- Accepting states with no valid: next state IDLE.
- exe_mem_valid while in ACCESS is ignored; upstream holds its data while mem_busy=1.
- ACCESS outputs: dmem_read or dmem_write, dmem_address, dmem_wmask and dmem_wdata are all registered and stable until dmem_resp. On dmem_resp: requests drop the next cycle; next state DONE.
- DONE: mem_rdy=1, with mem_result, mem_fwd_data, br_en_o and mem_err updated that same cycle.
- Latency:
  - Non-memory op: mem_rdy one cycle after accept.
  - Memory op: mem_rdy one cycle after dmem_resp.
  - Back-to-back non-memory ops give mem_rdy=1 every cycle.
- Alignment: H/HU with addr[0]=1, or W with addr[1:0]!=0, is misaligned. Misaligned or illegal funct3 (011/110/111) on a load or store issues no memory request; DONE with mem_err=1, mem_result=0.
- Stores (o = addr[1:0]):
  - SB: wmask = 4'b0001<<o; wdata = {4{rs2[7:0]}}.
  - SH: wmask = 4'b0011<<o; wdata = {2{rs2[15:0]}}.
  - SW: wmask = 4'b1111; wdata = rs2.
  - mem_result = 0 for stores.
- Loads: select byte o or halfword o[1] from dmem_rdata. B/H sign-extend, BU/HU zero-extend, W passes through.
- mem_err=0 on all normal completions. br_en_o passes through regardless of op type.

Test Plan:
- Reset asserted mid-ACCESS -> dmem_read falls in the same cycle, outputs 0; a dmem_resp pulse one cycle after reset release -> no mem_rdy.
- Non-memory ops, alu_out_i=0x1234_5678 then 0x0000_0042 on consecutive cycles -> mem_rdy high 2 cycles; mem_result 0x12345678 then 0x42; mem_busy stays 0.
- LB at 0x1000_0003, dmem_rdata=0x80FF_0000, dmem_resp 3 cycles after request -> dmem_address 0x10000000, dmem_read held 3 cycles, mem_busy=1 throughout, mem_result 0xFFFF_FF80 one cycle after resp; same access as LBU -> 0x0000_0080.
- SH at 0x2000_0002 with rs2=0xDEAD_BEEF -> dmem_wmask 4'b1100, dmem_wdata 0xBEEF_BEEF, dmem_write held until resp, mem_rdy with mem_result 0.
- LW at 0x3000_0001 -> no dmem_read ever asserted; mem_rdy with mem_err=1 one cycle after accept.
- exe_mem_valid pulsed during ACCESS with alu_out 0xAAAA_AAAA -> ignored; mem_fwd_data keeps the previous value until the load completes; br_en_i=1 on a non-memory op -> br_en_o=1 with mem_rdy.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus between the memory stage and data memory
interface mem_stage_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );
  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage issuing loads/stores and returning registered writeback results
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_mem_valid,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_out_i,
  input  logic        br_en_i,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic [2:0]  funct3,
  mem_stage_if.master dmem,
  output logic        mem_busy,
  output logic        mem_rdy,
  output logic [31:0] mem_result,
  output logic [31:0] mem_fwd_data,
  output logic        br_en_o,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, res_q, res_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        rd_q, rd_d, wr_q, wr_d, br_q, br_d, bra_q, bra_d, err_q, err_d;
  logic        illegal, misaligned, mem_op, go;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  assign illegal    = funct3 == 3'b011 || funct3[2:1] == 2'b11;
  assign misaligned = (funct3[1:0] == 2'b01 && alu_out_i[0]) || (funct3[1:0] == 2'b10 && alu_out_i[1:0] != 2'b00);
  assign mem_op     = ld_en || st_en;
  assign go         = mem_op && !illegal && !misaligned;
  assign ld_b       = dmem.dmem_rdata[8*off_q +: 8];
  assign ld_h       = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
  assign ld_val     = f3_q == 3'b000 ? {{24{ld_b[7]}}, ld_b} :
                      f3_q == 3'b100 ? {24'b0, ld_b} :
                      f3_q == 3'b001 ? {{16{ld_h[15]}}, ld_h} :
                      f3_q == 3'b101 ? {16'b0, ld_h} : dmem.dmem_rdata;
  // next state: accept in IDLE/DONE, complete ACCESS on dmem_resp
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    res_d   = res_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    br_d    = br_q;
    bra_d   = bra_q;
    err_d   = err_q;
    if (state_q == ACCESS) begin
      if (dmem.dmem_resp) begin
        state_d = DONE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        res_d   = wr_q ? 32'b0 : ld_val;
        err_d   = 1'b0;
        br_d    = bra_q;
      end
    end else if (exe_mem_valid) begin
      bra_d = br_en_i;
      off_d = alu_out_i[1:0];
      f3_d  = funct3;
      if (go) begin
        state_d = ACCESS;
        rd_d    = ld_en;
        wr_d    = st_en;
        addr_d  = {alu_out_i[31:2], 2'b00};
        wmask_d = !st_en ? 4'b0000 :
                  funct3[1:0] == 2'b00 ? 4'b0001 << alu_out_i[1:0] :
                  funct3[1:0] == 2'b01 ? 4'b0011 << alu_out_i[1:0] : 4'b1111;
        wdata_d = !st_en ? 32'b0 :
                  funct3[1:0] == 2'b00 ? {4{rs2_out_i[7:0]}} :
                  funct3[1:0] == 2'b01 ? {2{rs2_out_i[15:0]}} : rs2_out_i;
      end else begin
        state_d = DONE;
        res_d   = mem_op ? 32'b0 : alu_out_i;
        err_d   = mem_op;
        br_d    = br_en_i;
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state and datapath registers; reset drops any in-flight request at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      br_q    <= 1'b0;
      bra_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      res_q   <= res_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      br_q    <= br_d;
      bra_q   <= bra_d;
      err_q   <= err_d;
    end
  end
  assign dmem.dmem_address = addr_q;
  assign dmem.dmem_read    = rd_q;
  assign dmem.dmem_write   = wr_q;
  assign dmem.dmem_wmask   = wmask_q;
  assign dmem.dmem_wdata   = wdata_q;
  assign mem_busy          = state_q == ACCESS;
  assign mem_rdy           = state_q == DONE;
  assign mem_result        = res_q;
  assign mem_fwd_data      = res_q;
  assign br_en_o           = br_q;
  assign mem_err           = err_q;
endmodule
